// File: rtl/c2_bus_arbiter.sv
// Round-robin arbiter that shares one C2 memory bus among line-granular requesters,
// sequencing one whole-line read or write at a time with a response watchdog.
module c2_bus_arbiter #(
   parameter int NREQ       = 2,
   parameter int ADDR_W     = 15,
   parameter int BUS_W      = 16,
   parameter int LINE_BEATS = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [2*NREQ-1:0]        req_cmd,
   input  logic [ADDR_W*NREQ-1:0]   req_addr,
   input  logic [BUS_W*NREQ-1:0]    req_wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          wready,
   output logic [BUS_W-1:0]         rdata,
   output logic [NREQ-1:0]          rvalid,
   output logic [NREQ-1:0]          done,
   output logic [NREQ-1:0]          err,
   output logic [1:0]               mem_cmd,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [BUS_W-1:0]         mem_wdata,
   output logic                     mem_wvalid,
   input  logic [BUS_W-1:0]         mem_rdata,
   input  logic                     mem_rvalid,
   input  logic                     mem_ack
);

   localparam int IDX_W  = $clog2(NREQ);
   localparam int BEAT_W = $clog2(LINE_BEATS) + 1;
   localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [1:0] CMD_NOP   = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd2;
   localparam logic [1:0] CMD_WRITE = 2'd3;

   typedef enum logic [2:0] {IDLE, ISSUE, WDATA, WACK, RDATA, DONE} state_t;

   state_t              state, next_state;
   logic [NREQ-1:0]     pending;
   logic                any_pending;
   logic [IDX_W-1:0]    arb_idx, win_idx, rr_ptr;
   logic [1:0]          arb_cmd, cmd_lat;
   logic [ADDR_W-1:0]   arb_addr;
   logic [NREQ-1:0]     arb_onehot, win_onehot;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [WD_W-1:0]     wd_cnt;
   logic                wd_expired;
   logic                beat_in;
   logic [NREQ-1:0]     gnt_d, wready_d, rvalid_d, done_d, err_d;
   logic [1:0]          mem_cmd_d;
   logic                mem_wvalid_d;

   // Search starts just after the last winner so every pending requester gets a turn.
   always_comb begin
      int idx;
      idx         = 0;
      pending     = '0;
      any_pending = 1'b0;
      arb_idx     = '0;
      for (int i = 0; i < NREQ; i++)
         pending[i] = (req_cmd[2*i +: 2] == CMD_READ) || (req_cmd[2*i +: 2] == CMD_WRITE);
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!any_pending && pending[idx]) begin
            any_pending = 1'b1;
            arb_idx     = IDX_W'(idx);
         end
      end
   end

   assign arb_cmd    = req_cmd[2*arb_idx +: 2];
   assign arb_addr   = req_addr[ADDR_W*arb_idx +: ADDR_W];
   assign arb_onehot = NREQ'(1) << arb_idx;
   assign win_onehot = NREQ'(1) << win_idx;
   assign mem_wdata  = req_wdata[BUS_W*win_idx +: BUS_W];
   assign beat_in    = (state == RDATA) && mem_rvalid;
   assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_pending) next_state = ISSUE;
         ISSUE:   next_state = (cmd_lat == CMD_WRITE) ? WDATA : RDATA;
         WDATA:   if (beat_cnt == LAST_BEAT) next_state = WACK;
         WACK:    if (mem_ack || wd_expired) next_state = DONE;
         RDATA: begin
            if (mem_rvalid ? (beat_cnt == LAST_BEAT) : wd_expired)
               next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Entering DONE without the memory event that normally ends the phase means the watchdog fired.
   always_comb begin
      gnt_d        = '0;
      wready_d     = '0;
      rvalid_d     = '0;
      done_d       = '0;
      err_d        = '0;
      mem_cmd_d    = CMD_NOP;
      mem_wvalid_d = 1'b0;
      case (next_state)
         ISSUE: begin
            gnt_d     = arb_onehot;
            mem_cmd_d = arb_cmd;
         end
         WDATA: begin
            gnt_d        = win_onehot;
            wready_d     = win_onehot;
            mem_wvalid_d = 1'b1;
         end
         WACK, RDATA: gnt_d = win_onehot;
         DONE: begin
            done_d = win_onehot;
            if ((state == WACK && !mem_ack) || (state == RDATA && !mem_rvalid))
               err_d = win_onehot;
         end
         default: ;
      endcase
      if (beat_in)
         rvalid_d = win_onehot;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt        <= '0;
         wready     <= '0;
         rvalid     <= '0;
         done       <= '0;
         err        <= '0;
         mem_cmd    <= CMD_NOP;
         mem_wvalid <= 1'b0;
         mem_addr   <= '0;
         rdata      <= '0;
         cmd_lat    <= CMD_NOP;
         win_idx    <= '0;
         rr_ptr     <= IDX_W'(NREQ - 1);
         beat_cnt   <= '0;
         wd_cnt     <= '0;
      end else begin
         gnt        <= gnt_d;
         wready     <= wready_d;
         rvalid     <= rvalid_d;
         done       <= done_d;
         err        <= err_d;
         mem_cmd    <= mem_cmd_d;
         mem_wvalid <= mem_wvalid_d;
         if (state == IDLE && next_state == ISSUE) begin
            cmd_lat  <= arb_cmd;
            mem_addr <= arb_addr;
            win_idx  <= arb_idx;
            rr_ptr   <= arb_idx;
         end
         if (beat_in)
            rdata <= mem_rdata;
         if (next_state == DONE || next_state == WACK)
            beat_cnt <= '0;
         else if (state == WDATA || beat_in)
            beat_cnt <= beat_cnt + 1'b1;
         // Idle time only accumulates while waiting on memory; any read beat restarts it.
         if ((state == WACK || state == RDATA) && next_state == state && !beat_in)
            wd_cnt <= wd_cnt + 1'b1;
         else
            wd_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_c2_bus_arbiter.sv
// Directed bench for c2_bus_arbiter: reads, writes, contention, gapped reads,
// watchdog timeout and mid-transaction reset, checked cycle by cycle.
module tb_c2_bus_arbiter;

   localparam logic [1:0] NOP   = 2'd0;
   localparam logic [1:0] READ  = 2'd2;
   localparam logic [1:0] WRITE = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_cmd;
   logic [29:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  gnt, wready, rvalid, done, err;
   logic [15:0] rdata, mem_wdata, mem_rdata;
   logic [1:0]  mem_cmd;
   logic [14:0] mem_addr;
   logic        mem_wvalid, mem_rvalid, mem_ack;

   int compared   = 0;
   int mismatched = 0;

   c2_bus_arbiter #(
      .NREQ(2), .ADDR_W(15), .BUS_W(16), .LINE_BEATS(8), .TIMEOUT(4)
   ) dut (
      .clk(clk), .reset(reset),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .wready(wready), .rdata(rdata), .rvalid(rvalid),
      .done(done), .err(err),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wvalid(mem_wvalid), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int r, input logic [1:0] cmd, input logic [14:0] addr,
                                input logic [15:0] wdata);
      req_cmd[2*r +: 2]    = cmd;
      req_addr[15*r +: 15] = addr;
      req_wdata[16*r +: 16] = wdata;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".gnt"},        32'(gnt),        32'h0);
      checkOutput({tag, ".wready"},     32'(wready),     32'h0);
      checkOutput({tag, ".rvalid"},     32'(rvalid),     32'h0);
      checkOutput({tag, ".done"},       32'(done),       32'h0);
      checkOutput({tag, ".err"},        32'(err),        32'h0);
      checkOutput({tag, ".mem_wvalid"}, 32'(mem_wvalid), 32'h0);
      checkOutput({tag, ".mem_cmd"},    32'(mem_cmd),    32'h0);
      checkOutput({tag, ".mem_addr"},   32'(mem_addr),   32'h0);
      checkOutput({tag, ".rdata"},      32'(rdata),      32'h0);
   endtask

   // Called in the first RDATA cycle; returns in the DONE cycle.
   task automatic contiguousRead(input int who, input logic [15:0] base, input string tag);
      logic [1:0] oh;
      oh = 2'b01 << who;
      for (int k = 0; k < 8; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + 16'(k);
         tick;
         checkOutput({tag, ".rvalid"}, 32'(rvalid), 32'(oh));
         checkOutput({tag, ".rdata"},  32'(rdata),  32'(base + 16'(k)));
         checkOutput({tag, ".done"},   32'(done),   32'((k == 7) ? oh : 2'b00));
      end
      mem_rvalid = 1'b0;
      checkOutput({tag, ".err"}, 32'(err), 32'h0);
      checkOutput({tag, ".gnt_done"}, 32'(gnt), 32'h0);
   endtask

   initial begin
      reset      = 1'b1;
      req_cmd    = '0;
      req_addr   = '0;
      req_wdata  = '0;
      mem_rdata  = '0;
      mem_rvalid = 1'b0;
      mem_ack    = 1'b0;
      #2;
      checkResetValues("por");
      tick;
      tick;
      reset = 1'b0;

      // Single read from requester 0
      applyStimulus(0, READ, 15'h01A3, 16'h0);
      tick;
      checkOutput("rd1.gnt_issue", 32'(gnt), 32'h1);
      checkOutput("rd1.mem_cmd",   32'(mem_cmd), 32'(READ));
      checkOutput("rd1.mem_addr",  32'(mem_addr), 32'h01A3);
      tick;
      checkOutput("rd1.mem_cmd_nop", 32'(mem_cmd), 32'(NOP));
      checkOutput("rd1.gnt_rdata",   32'(gnt), 32'h1);
      contiguousRead(0, 16'h0000, "rd1");
      applyStimulus(0, NOP, 15'h0, 16'h0);
      tick;
      checkOutput("rd1.done_clear", 32'(done), 32'h0);
      checkOutput("rd1.gnt_idle",   32'(gnt), 32'h0);

      // Single write from requester 1
      applyStimulus(1, WRITE, 15'h0042, 16'h00A0);
      tick;
      checkOutput("wr1.gnt_issue", 32'(gnt), 32'h2);
      checkOutput("wr1.mem_cmd",   32'(mem_cmd), 32'(WRITE));
      checkOutput("wr1.mem_addr",  32'(mem_addr), 32'h0042);
      tick;
      for (int k = 0; k < 8; k++) begin
         checkOutput("wr1.mem_wvalid", 32'(mem_wvalid), 32'h1);
         checkOutput("wr1.wready",     32'(wready), 32'h2);
         checkOutput("wr1.mem_wdata",  32'(mem_wdata), 32'(16'h00A0 + 16'(k)));
         applyStimulus(1, WRITE, 15'h0042, 16'h00A0 + 16'(k + 1));
         tick;
      end
      checkOutput("wr1.wvalid_off", 32'(mem_wvalid), 32'h0);
      checkOutput("wr1.wready_off", 32'(wready), 32'h0);
      checkOutput("wr1.gnt_wack",   32'(gnt), 32'h2);
      tick;
      checkOutput("wr1.done_wait", 32'(done), 32'h0);
      tick;
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      checkOutput("wr1.done", 32'(done), 32'h2);
      checkOutput("wr1.err",  32'(err), 32'h0);
      checkOutput("wr1.gnt_done", 32'(gnt), 32'h0);
      applyStimulus(1, NOP, 15'h0, 16'h0);
      tick;
      checkOutput("wr1.done_clear", 32'(done), 32'h0);

      // Contention from reset: both read continuously, grants alternate
      reset = 1'b1;
      tick;
      reset = 1'b0;
      applyStimulus(0, READ, 15'h0010, 16'h0);
      applyStimulus(1, READ, 15'h0020, 16'h0);
      for (int t = 0; t < 4; t++) begin
         tick;
         checkOutput("cont.gnt", 32'(gnt), 32'((t % 2 == 0) ? 2'b01 : 2'b10));
         checkOutput("cont.mem_addr", 32'(mem_addr), 32'((t % 2 == 0) ? 15'h0010 : 15'h0020));
         tick;
         contiguousRead(t % 2, 16'(t * 16), "cont");
         applyStimulus(t % 2, NOP, 15'h0, 16'h0);
         tick;
         checkOutput("cont.gnt_idle", 32'(gnt), 32'h0);
         checkOutput("cont.done_idle", 32'(done), 32'h0);
         if (t < 3)
            applyStimulus(t % 2, READ, (t % 2 == 0) ? 15'h0010 : 15'h0020, 16'h0);
      end

      // Gapped read with a stray mem_ack in a gap
      applyStimulus(0, READ, 15'h0055, 16'h0);
      tick;
      checkOutput("gap.gnt", 32'(gnt), 32'h1);
      checkOutput("gap.mem_addr", 32'(mem_addr), 32'h0055);
      tick;
      for (int k = 0; k < 8; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 16'h0100 + 16'(k);
         tick;
         checkOutput("gap.rvalid", 32'(rvalid), 32'h1);
         checkOutput("gap.rdata",  32'(rdata), 32'(16'h0100 + 16'(k)));
         checkOutput("gap.done",   32'(done), 32'((k == 7) ? 2'b01 : 2'b00));
         mem_rvalid = 1'b0;
         if (k < 7) begin
            mem_ack = (k == 2);
            tick;
            mem_ack = 1'b0;
            checkOutput("gap.rvalid_gap", 32'(rvalid), 32'h0);
            checkOutput("gap.done_gap",   32'(done), 32'h0);
         end
      end
      checkOutput("gap.err", 32'(err), 32'h0);
      applyStimulus(0, NOP, 15'h0, 16'h0);
      tick;
      mem_rvalid = 1'b1;
      tick;
      mem_rvalid = 1'b0;
      checkOutput("gap.stray_rvalid", 32'(rvalid), 32'h0);
      checkOutput("gap.stray_gnt",    32'(gnt), 32'h0);

      // Write whose acknowledge never arrives trips the watchdog
      applyStimulus(0, WRITE, 15'h03FF, 16'h5500);
      tick;
      checkOutput("to.gnt", 32'(gnt), 32'h1);
      checkOutput("to.mem_cmd", 32'(mem_cmd), 32'(WRITE));
      tick;
      for (int k = 0; k < 8; k++) begin
         checkOutput("to.mem_wdata", 32'(mem_wdata), 32'(16'h5500 + 16'(k)));
         applyStimulus(0, WRITE, 15'h03FF, 16'h5500 + 16'(k + 1));
         tick;
      end
      for (int c = 1; c <= 4; c++) begin
         tick;
         checkOutput("to.done", 32'(done), 32'((c == 4) ? 2'b01 : 2'b00));
         checkOutput("to.err",  32'(err),  32'((c == 4) ? 2'b01 : 2'b00));
      end
      checkOutput("to.gnt_done", 32'(gnt), 32'h0);
      mem_ack = 1'b1;
      applyStimulus(0, NOP, 15'h0, 16'h0);
      tick;
      mem_ack = 1'b0;
      checkOutput("to.late_done", 32'(done), 32'h0);
      checkOutput("to.late_err",  32'(err), 32'h0);
      applyStimulus(1, READ, 15'h7FFF, 16'h0);
      tick;
      checkOutput("to.next_gnt", 32'(gnt), 32'h2);
      checkOutput("to.next_addr", 32'(mem_addr), 32'h7FFF);
      tick;
      contiguousRead(1, 16'hFFF0, "to_next");
      applyStimulus(1, NOP, 15'h0, 16'h0);
      tick;

      // Reset in the middle of a read after four beats
      applyStimulus(1, READ, 15'h0123, 16'h0);
      tick;
      checkOutput("mid.gnt", 32'(gnt), 32'h2);
      tick;
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 16'h0200 + 16'(k);
         tick;
         checkOutput("mid.rvalid", 32'(rvalid), 32'h2);
         checkOutput("mid.rdata",  32'(rdata), 32'(16'h0200 + 16'(k)));
      end
      reset      = 1'b1;
      mem_rvalid = 1'b0;
      #1;
      checkResetValues("mid");
      tick;
      checkOutput("mid.done_in_reset", 32'(done), 32'h0);
      reset = 1'b0;
      applyStimulus(0, READ, 15'h0001, 16'h0);
      applyStimulus(1, READ, 15'h0002, 16'h0);
      tick;
      checkOutput("mid.first_winner", 32'(gnt), 32'h1);
      checkOutput("mid.first_addr",   32'(mem_addr), 32'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
